// File: rtl/trunc_pkg.sv
// Shared definitions for the bit-field truncation pipeline.
package trunc_pkg;

  typedef logic [1:0] trunc_mode_t;

  // Operating modes carried on in_mode
  localparam trunc_mode_t TRUNC_LOW_ZX  = 2'b00;  // keep low L bits, zero above
  localparam trunc_mode_t TRUNC_HIGH_RA = 2'b01;  // top L bits moved down, zero-filled
  localparam trunc_mode_t TRUNC_LOW_SX  = 2'b10;  // keep low L bits, sign-extend bit L-1
  localparam trunc_mode_t TRUNC_HIGH_LA = 2'b11;  // keep top L bits in place

  // Clamp a requested length to the data width.
  function automatic int unsigned f_clamp_len(input int unsigned len,
                                              input int unsigned width);
    return (len > width) ? width : len;
  endfunction

endpackage

// File: rtl/trunc_mask_gen.sv
// Combinational low-bit mask: bit i is set when i < len_i.
// A per-bit compare avoids any shift, so len_i == WIDTH needs no special case.
module trunc_mask_gen #(
  parameter int WIDTH = 32,
  parameter int LEN_W = $clog2(WIDTH) + 1
) (
  input  logic [LEN_W-1:0] len_i,
  output logic [WIDTH-1:0] mask_o
);

  // Thermometer decode of the (already clamped) length
  always_comb begin
    mask_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      mask_o[i] = (LEN_W'(i) < len_i);
    end
  end

endmodule

// File: rtl/trunc_pipe.sv
// Two-stage pipelined bit-field truncation unit.
// Stage 1 captures the operand, clamped length, mode, saturation flag and
// the low-bit mask; stage 2 forms and holds the result. Both stages use a
// skid-free valid/ready scheme: a stage loads when it is empty or when its
// content moves on in the same cycle.
module trunc_pipe
  import trunc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LEN_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LEN_W-1:0] in_len,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sat
);

  localparam logic [LEN_W-1:0] WIDTH_LEN = LEN_W'(WIDTH);

  // ---------------------------------------------------------------------
  // Stage 1 state
  // ---------------------------------------------------------------------
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_data_q;
  logic [LEN_W-1:0] s1_len_q;
  trunc_mode_t      s1_mode_q;
  logic             s1_sat_q;
  logic [WIDTH-1:0] s1_mask_q;

  // Stage 2 (output) state
  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_data_q;
  logic             s2_sat_q;

  // Handshake
  logic s2_load;
  logic s1_load;

  // Stage 1 inputs
  logic [LEN_W-1:0] len_d;
  logic             sat_d;
  logic [WIDTH-1:0] mask_d;

  // Stage 2 inputs
  logic [WIDTH-1:0] mask_rev;
  logic [WIDTH-1:0] top_bit;
  logic [LEN_W-1:0] shamt;
  logic             sign;
  logic [WIDTH-1:0] res_d;

  // Output stage loads when empty or draining; stage 1 advances with it.
  // in_ready never looks at in_valid, so an idle upstream cannot loop back.
  assign s2_load  = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_load;
  assign s1_load  = in_valid && in_ready;

  // Length clamp and saturation flag
  always_comb begin
    len_d = LEN_W'(f_clamp_len(32'(in_len), WIDTH));
    sat_d = (in_len > WIDTH_LEN);
  end

  trunc_mask_gen #(
    .WIDTH (WIDTH),
    .LEN_W (LEN_W)
  ) u_mask (
    .len_i  (len_d),
    .mask_o (mask_d)
  );

  // Stage 1 register: valid follows the input whenever the stage can take
  // a beat; payload only loads on a real transfer so X on idle inputs stays out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_len_q   <= '0;
      s1_mode_q  <= TRUNC_LOW_ZX;
      s1_sat_q   <= 1'b0;
      s1_mask_q  <= '0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (s1_load) begin
        s1_data_q <= in_data;
        s1_len_q  <= len_d;
        s1_mode_q <= in_mode;
        s1_sat_q  <= sat_d;
        s1_mask_q <= mask_d;
      end
    end
  end

  // Result formation from the stage 1 registers.
  // The high-aligned mask (top L bits) is the bit reverse of mask(L), which
  // equals ~mask(WIDTH-L) without a second generator.
  // Bit L-1 is isolated as the highest set bit of the mask (mask & ~(mask>>1)),
  // so no variable bit-select is needed and L=0 naturally yields sign=0.
  always_comb begin
    mask_rev = '0;
    for (int i = 0; i < WIDTH; i++) begin
      mask_rev[i] = s1_mask_q[WIDTH-1-i];
    end
    top_bit = s1_mask_q & ~(s1_mask_q >> 1);
    sign    = |(s1_data_q & top_bit);
    shamt   = WIDTH_LEN - s1_len_q;
    res_d   = '0;
    case (s1_mode_q)
      TRUNC_LOW_ZX: res_d = s1_data_q & s1_mask_q;
      TRUNC_HIGH_RA: begin
        // L=0 would need a shift by WIDTH; handled explicitly instead
        if (s1_len_q == '0) res_d = '0;
        else                res_d = s1_data_q >> shamt;
      end
      TRUNC_LOW_SX: res_d = (s1_data_q & s1_mask_q) | ({WIDTH{sign}} & ~s1_mask_q);
      TRUNC_HIGH_LA: res_d = s1_data_q & mask_rev;
      default: res_d = '0;
    endcase
  end

  // Stage 2 register: holds steady while stalled, payload only changes
  // when a valid beat moves in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_sat_q   <= 1'b0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_data_q <= res_d;
        s2_sat_q  <= s1_sat_q;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_sat   = s2_sat_q;

endmodule

// File: tb/tb_trunc_pipe.sv
// Directed bench for trunc_pipe at WIDTH=32.
module tb_trunc_pipe;

  localparam int WIDTH = 32;
  localparam int LEN_W = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [LEN_W-1:0] in_len;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_sat;

  trunc_pipe #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_len    (in_len),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] data;
    logic [5:0]  len;
    logic [31:0] res;
    logic        sat;
  } vec_t;

  vec_t tbl[$];

  // One beat through an unstalled pipe; result must appear 2 cycles after accept
  task automatic run_one(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    in_valid = 1'b1; in_data = v.data; in_len = v.len; in_mode = v.mode; out_ready = 1'b1;
    #1 chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_lat1"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    chk({tag, "_vld"}, 64'(out_valid), 64'd1);
    chk({tag, "_dat"}, 64'(out_data), 64'(v.res));
    chk({tag, "_sat"}, 64'(out_sat), 64'(v.sat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] exp_q[$];
    logic [32:0] held, e;
    logic        held_v;
    int          sent, got, occ;

    // Hand-computed vectors
    tbl.push_back('{2'b00, 32'hDEADBEEF, 6'd8,  32'h000000EF, 1'b0});
    tbl.push_back('{2'b01, 32'hDEADBEEF, 6'd12, 32'h00000DEA, 1'b0});
    tbl.push_back('{2'b01, 32'hDEADBEEF, 6'd0,  32'h00000000, 1'b0});
    tbl.push_back('{2'b01, 32'hDEADBEEF, 6'd32, 32'hDEADBEEF, 1'b0});
    tbl.push_back('{2'b10, 32'h000000F0, 6'd8,  32'hFFFFFFF0, 1'b0});
    tbl.push_back('{2'b11, 32'hDEADBEEF, 6'd4,  32'hD0000000, 1'b0});
    tbl.push_back('{2'b00, 32'hDEADBEEF, 6'd40, 32'hDEADBEEF, 1'b1});
    tbl.push_back('{2'b01, 32'hDEADBEEF, 6'd40, 32'hDEADBEEF, 1'b1});
    tbl.push_back('{2'b10, 32'hDEADBEEF, 6'd40, 32'hDEADBEEF, 1'b1});
    tbl.push_back('{2'b11, 32'hDEADBEEF, 6'd63, 32'hDEADBEEF, 1'b1});
    tbl.push_back('{2'b10, 32'h00000070, 6'd8,  32'h00000070, 1'b0});
    tbl.push_back('{2'b00, 32'hDEADBEEF, 6'd0,  32'h00000000, 1'b0});
    tbl.push_back('{2'b10, 32'hDEADBEEF, 6'd0,  32'h00000000, 1'b0});
    tbl.push_back('{2'b11, 32'hDEADBEEF, 6'd0,  32'h00000000, 1'b0});
    tbl.push_back('{2'b10, 32'hDEADBEEF, 6'd1,  32'hFFFFFFFF, 1'b0});
    tbl.push_back('{2'b01, 32'hDEADBEEF, 6'd1,  32'h00000001, 1'b0});
    tbl.push_back('{2'b11, 32'hDEADBEEF, 6'd32, 32'hDEADBEEF, 1'b0});
    tbl.push_back('{2'b10, 32'hDEADBEEF, 6'd16, 32'hFFFFBEEF, 1'b0});
    tbl.push_back('{2'b00, 32'hDEADBEEF, 6'd31, 32'h5EADBEEF, 1'b0});
    tbl.push_back('{2'b10, 32'hDEADBEEF, 6'd32, 32'hDEADBEEF, 1'b0});
    tbl.push_back('{2'b00, 32'hDEADBEEF, 6'd33, 32'hDEADBEEF, 1'b1});

    // Reset state
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_len = '0; in_mode = '0; out_ready = 1'b0;
    #12;
    chk("rst_vld", 64'(out_valid), 64'd0);
    chk("rst_dat", 64'(out_data), 64'd0);
    chk("rst_sat", 64'(out_sat), 64'd0);
    chk("rst_rdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with undriven mode must not create output beats
    in_mode = 2'bxx;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_x_vld", 64'(out_valid), 64'd0);
    end

    foreach (tbl[i]) run_one(tbl[i], i);

    // Back-to-back stream with random backpressure
    @(negedge clk);
    sent = 0; got = 0; occ = 0; held_v = 1'b0; held = '0;
    for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
      @(negedge clk);
      if (held_v) begin
        chk("hold_vld", 64'(out_valid), 64'd1);
        chk("hold_dat", 64'({out_sat, out_data}), 64'(held));
      end
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 16) begin
        in_valid = 1'b1;
        in_data  = 32'hC0DE0000 ^ 32'(sent * 7919);
        in_len   = (sent % 2 == 1) ? 6'd40 : 6'd32;
        in_mode  = 2'(sent % 4);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      chk("strm_rdy", 64'(in_ready), 64'(!(occ == 2 && !out_ready)));
      held_v = out_valid && !out_ready;
      held   = {out_sat, out_data};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("strm_dup", 64'(got), 64'd16);
        end else begin
          e = exp_q.pop_front();
          chk("strm_dat", 64'({out_sat, out_data}), 64'(e));
        end
        got++; occ--;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({in_len > 6'd32, in_data});
        sent++; occ++;
      end
    end
    chk("strm_cnt", 64'(got), 64'd16);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("strm_extra", 64'(out_valid), 64'd0);
    end

    // Reset with two beats in flight
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h11111111; in_len = 6'd32; in_mode = 2'b00;
    @(negedge clk);
    in_data = 32'h22222222;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_vld", 64'(out_valid), 64'd1);
    chk("pre_rst_rdy", 64'(in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 64'(out_valid), 64'd0);
    chk("mid_rst_dat", 64'(out_data), 64'd0);
    chk("mid_rst_rdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1 chk("post_rst_rdy", 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_stale", 64'(out_valid), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
